// File: rtl/microseq_controller.sv
// Multi-cycle fetch/decode/execute sequencer driving the tiny16 ALU, memory and register-file strobes.
// Define MICROSEQ_IRQ_EN to add the irq/irq_ack interrupt entry sequence and the interrupt-enable bit.
module microseq_controller #(
  parameter int         DATA_W   = 16,
  parameter logic [2:0] PC_SEL   = 3'd0,
  parameter int         WAIT_MAX = 15
`ifdef MICROSEQ_IRQ_EN
  , parameter logic [15:0] IRQ_VECTOR = 16'h0010
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic [3:0]        flags,
  input  logic              mem_ready,
`ifdef MICROSEQ_IRQ_EN
  input  logic              irq,
  output logic              irq_ack,
`endif
  output logic [3:0]        alu_opcode,
  output logic              alu_out_en,
  output logic              alu_ar_flag,
  output logic              mem_addr_en,
  output logic              mem_in_en,
  output logic              mem_out_en,
  output logic [2:0]        reg_src_sel,
  output logic [2:0]        reg_dst_sel,
  output logic              reg_in_en,
  output logic              reg_out_en,
  output logic              reg_pc_inc,
  output logic [DATA_W-1:0] out,
  output logic              out_en,
  output logic              halted,
  output logic              fault
);
  localparam int OFF_W = DATA_W - 12;
  localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [3:0] OP_SYS = 4'd0;
  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_ST  = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd11;
  localparam logic [3:0] OP_JMP = 4'd12;
  localparam logic [3:0] OP_JSR = 4'd13;
  localparam logic [3:0] OP_CMP = 4'd14;
  localparam logic [3:0] OP_BR  = 4'd15;

  typedef enum logic [3:0] {
    FETCH_A, FETCH_D, DECODE, EX1, EX2, IRQ1, IRQ2, HALT, FAULT
  } step_t;

  step_t             step_reg;
  logic [DATA_W-1:0] ir_reg;
  logic [3:0]        flags_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;
`ifdef MICROSEQ_IRQ_EN
  logic              ie_reg;
`endif

  logic [3:0]        op;
  logic              imm;
  logic [2:0]        dst;
  logic              ind;
  logic [2:0]        src;
  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] off_zx;
  logic [DATA_W-1:0] off_sx;

  assign op     = ir_reg[DATA_W-1 -: 4];
  assign imm    = ir_reg[DATA_W-5];
  assign dst    = ir_reg[DATA_W-6 -: 3];
  assign ind    = ir_reg[DATA_W-9];
  assign src    = ir_reg[DATA_W-10 -: 3];
  assign off    = ir_reg[OFF_W-1:0];
  assign off_zx = DATA_W'(off);
  assign off_sx = DATA_W'(signed'(off));

  logic is_alu, two_step, mem_op, mem_wait, wait_limit, br_taken, do_jump;

  assign is_alu     = (op >= 4'd3) && (op <= 4'd11);
  assign mem_op     = (op == OP_LD) || (op == OP_ST);
  assign two_step   = is_alu || (op == OP_CMP) || (op == OP_ST) || (op == OP_JSR) ||
                      ((op == OP_LD) && !imm);
  assign mem_wait   = (step_reg == FETCH_D) || ((step_reg == EX2) && mem_op);
  // Fault on the edge that would take the count to WAIT_MAX; mem_ready on that edge still wins.
  assign wait_limit = (WAIT_MAX > 0) && ((int'(wait_cnt_reg) + 1) >= WAIT_MAX);

  always_comb begin
    case (dst)
      3'd0:    br_taken = 1'b1;
      3'd1:    br_taken = flags_reg[0];
      3'd2:    br_taken = !flags_reg[0];
      3'd3:    br_taken = flags_reg[1];
      3'd4:    br_taken = !flags_reg[1];
      3'd5:    br_taken = flags_reg[2];
      3'd6:    br_taken = !flags_reg[2];
      default: br_taken = flags_reg[3];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_reg     <= FETCH_A;
      ir_reg       <= '0;
      flags_reg    <= '0;
      wait_cnt_reg <= '0;
`ifdef MICROSEQ_IRQ_EN
      ie_reg       <= 1'b0;
`endif
    end else begin
      if (mem_wait) begin
        if (mem_ready || wait_limit) wait_cnt_reg <= '0;
        else                         wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      end
      case (step_reg)
`ifdef MICROSEQ_IRQ_EN
        FETCH_A: step_reg <= (irq && ie_reg) ? IRQ1 : FETCH_D;
        IRQ1:    step_reg <= IRQ2;
        IRQ2: begin
          step_reg <= FETCH_A;
          ie_reg   <= 1'b0;
        end
`else
        FETCH_A: step_reg <= FETCH_D;
`endif
        FETCH_D: begin
          if (mem_ready) begin
            ir_reg    <= in;
            flags_reg <= flags;
            step_reg  <= DECODE;
          end else if (wait_limit) begin
            step_reg  <= FAULT;
          end
        end
        DECODE: step_reg <= EX1;
        EX1: begin
          if (two_step)                                    step_reg <= EX2;
          else if ((op == OP_SYS) && (off == OFF_W'(1)))   step_reg <= HALT;
          else                                             step_reg <= FETCH_A;
`ifdef MICROSEQ_IRQ_EN
          if ((op == OP_SYS) && (off == OFF_W'(2))) ie_reg <= 1'b1;
          if ((op == OP_SYS) && (off == OFF_W'(3))) ie_reg <= 1'b0;
`endif
        end
        EX2: begin
          if (!mem_op || mem_ready) step_reg <= FETCH_A;
          else if (wait_limit)      step_reg <= FAULT;
        end
        HALT, FAULT: step_reg <= step_reg;
        default:     step_reg <= FETCH_A;
      endcase
    end
  end

  // Strobes decode only registered state; all held low while reset is asserted.
  always_comb begin
    alu_opcode  = '0;
    alu_out_en  = 1'b0;
    alu_ar_flag = 1'b0;
    mem_addr_en = 1'b0;
    mem_in_en   = 1'b0;
    mem_out_en  = 1'b0;
    reg_src_sel = '0;
    reg_dst_sel = '0;
    reg_in_en   = 1'b0;
    reg_out_en  = 1'b0;
    reg_pc_inc  = 1'b0;
    out         = '0;
    out_en      = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    do_jump     = 1'b0;
`ifdef MICROSEQ_IRQ_EN
    irq_ack     = 1'b0;
`endif
    if (rst) begin
      case (step_reg)
        FETCH_A: begin
          reg_dst_sel = PC_SEL;
          reg_out_en  = 1'b1;
          mem_addr_en = 1'b1;
        end
        FETCH_D: mem_out_en = 1'b1;
        DECODE:  reg_pc_inc = 1'b1;
        EX1: begin
          case (op)
            OP_SYS: ;
            OP_LD: begin
              if (imm) begin
                out_en      = 1'b1;
                out         = off_zx;
                reg_dst_sel = dst;
                reg_in_en   = 1'b1;
              end else begin
                reg_src_sel = src;
                reg_out_en  = 1'b1;
                mem_addr_en = 1'b1;
              end
            end
            OP_ST: begin
              reg_src_sel = dst;
              reg_out_en  = 1'b1;
              mem_addr_en = 1'b1;
            end
            OP_JMP: do_jump = 1'b1;
            OP_JSR: begin
              reg_src_sel = PC_SEL;
              reg_out_en  = 1'b1;
              reg_dst_sel = dst;
              reg_in_en   = 1'b1;
            end
            OP_BR: begin
              if (br_taken) begin
                out_en      = 1'b1;
                out         = off_sx;
                reg_dst_sel = PC_SEL;
                reg_in_en   = 1'b1;
              end
            end
            default: begin
              alu_opcode  = op;
              reg_src_sel = src;
              reg_dst_sel = dst;
              alu_ar_flag = (op == OP_SHR) && ind;
              if (imm) begin
                out_en = 1'b1;
                out    = off_zx;
              end else begin
                reg_out_en = 1'b1;
              end
            end
          endcase
        end
        EX2: begin
          case (op)
            OP_LD: begin
              mem_out_en  = 1'b1;
              reg_dst_sel = dst;
              reg_in_en   = 1'b1;
            end
            OP_ST: begin
              reg_src_sel = src;
              reg_out_en  = 1'b1;
              mem_in_en   = 1'b1;
            end
            OP_JSR: do_jump = 1'b1;
            OP_CMP: begin
              alu_opcode  = op;
              reg_dst_sel = dst;
            end
            default: begin
              alu_opcode  = op;
              alu_out_en  = 1'b1;
              reg_dst_sel = dst;
              reg_in_en   = 1'b1;
              alu_ar_flag = (op == OP_SHR) && ind;
            end
          endcase
        end
`ifdef MICROSEQ_IRQ_EN
        IRQ1: begin
          reg_src_sel = PC_SEL;
          reg_out_en  = 1'b1;
          reg_dst_sel = 3'd7;
          reg_in_en   = 1'b1;
        end
        IRQ2: begin
          out         = DATA_W'(IRQ_VECTOR);
          out_en      = 1'b1;
          reg_dst_sel = PC_SEL;
          reg_in_en   = 1'b1;
          irq_ack     = 1'b1;
        end
`endif
        HALT:    halted = 1'b1;
        FAULT:   fault  = 1'b1;
        default: ;
      endcase
      if (do_jump) begin
        reg_dst_sel = PC_SEL;
        reg_in_en   = 1'b1;
        if (imm) begin
          out_en = 1'b1;
          out    = off_zx;
        end else begin
          reg_src_sel = src;
          reg_out_en  = 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_microseq_controller.sv
// Per-cycle vector table for microseq_controller plus hand-written reset, timeout
// and interrupt sequences; instance b runs with WAIT_MAX=2 for the timeout cases.
`timescale 1ns/1ps
module tb_microseq_controller;
  localparam logic [10:0] S_AOUT  = 11'h001;
  localparam logic [10:0] S_AR    = 11'h002;
  localparam logic [10:0] S_MADDR = 11'h004;
  localparam logic [10:0] S_MIN   = 11'h008;
  localparam logic [10:0] S_MOUT  = 11'h010;
  localparam logic [10:0] S_RIN   = 11'h020;
  localparam logic [10:0] S_ROUT  = 11'h040;
  localparam logic [10:0] S_PCINC = 11'h080;
  localparam logic [10:0] S_OUTEN = 11'h100;
  localparam logic [10:0] S_HALT  = 11'h200;
  localparam logic [10:0] S_FAULT = 11'h400;
  localparam logic [10:0] S_NONE  = 11'h000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_w;
  logic [3:0]  flags_w;
  logic        mem_ready, mem_ready_b;
`ifdef MICROSEQ_IRQ_EN
  logic        irq_w, irq_ack_a, irq_ack_b;
`endif

  logic [3:0]  alu_opcode_a, alu_opcode_b;
  logic        alu_out_en_a, alu_out_en_b, alu_ar_flag_a, alu_ar_flag_b;
  logic        mem_addr_en_a, mem_addr_en_b, mem_in_en_a, mem_in_en_b, mem_out_en_a, mem_out_en_b;
  logic [2:0]  reg_src_sel_a, reg_src_sel_b, reg_dst_sel_a, reg_dst_sel_b;
  logic        reg_in_en_a, reg_in_en_b, reg_out_en_a, reg_out_en_b, reg_pc_inc_a, reg_pc_inc_b;
  logic [15:0] out_a, out_b;
  logic        out_en_a, out_en_b, halted_a, halted_b, fault_a, fault_b;

  always #5 clk = ~clk;

  microseq_controller dut_a (
    .clk(clk), .rst(rst), .in(in_w), .flags(flags_w), .mem_ready(mem_ready),
`ifdef MICROSEQ_IRQ_EN
    .irq(irq_w), .irq_ack(irq_ack_a),
`endif
    .alu_opcode(alu_opcode_a), .alu_out_en(alu_out_en_a), .alu_ar_flag(alu_ar_flag_a),
    .mem_addr_en(mem_addr_en_a), .mem_in_en(mem_in_en_a), .mem_out_en(mem_out_en_a),
    .reg_src_sel(reg_src_sel_a), .reg_dst_sel(reg_dst_sel_a), .reg_in_en(reg_in_en_a),
    .reg_out_en(reg_out_en_a), .reg_pc_inc(reg_pc_inc_a), .out(out_a), .out_en(out_en_a),
    .halted(halted_a), .fault(fault_a)
  );

  microseq_controller #(.WAIT_MAX(2)) dut_b (
    .clk(clk), .rst(rst), .in(in_w), .flags(flags_w), .mem_ready(mem_ready_b),
`ifdef MICROSEQ_IRQ_EN
    .irq(irq_w), .irq_ack(irq_ack_b),
`endif
    .alu_opcode(alu_opcode_b), .alu_out_en(alu_out_en_b), .alu_ar_flag(alu_ar_flag_b),
    .mem_addr_en(mem_addr_en_b), .mem_in_en(mem_in_en_b), .mem_out_en(mem_out_en_b),
    .reg_src_sel(reg_src_sel_b), .reg_dst_sel(reg_dst_sel_b), .reg_in_en(reg_in_en_b),
    .reg_out_en(reg_out_en_b), .reg_pc_inc(reg_pc_inc_b), .out(out_b), .out_en(out_en_b),
    .halted(halted_b), .fault(fault_b)
  );

  logic [36:0] act_a, act_b;
  assign act_a = {fault_a, halted_a, out_en_a, reg_pc_inc_a, reg_out_en_a, reg_in_en_a,
                  mem_out_en_a, mem_in_en_a, mem_addr_en_a, alu_ar_flag_a, alu_out_en_a,
                  alu_opcode_a, reg_src_sel_a, reg_dst_sel_a, out_a};
  assign act_b = {fault_b, halted_b, out_en_b, reg_pc_inc_b, reg_out_en_b, reg_in_en_b,
                  mem_out_en_b, mem_in_en_b, mem_addr_en_b, alu_ar_flag_b, alu_out_en_b,
                  alu_opcode_b, reg_src_sel_b, reg_dst_sel_b, out_b};

  typedef struct {
    string       tag;
    logic [15:0] instr;
    logic [3:0]  flg;
    logic        rdy;
    logic [36:0] expv;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [36:0] ex(input logic [10:0] strb, input logic [3:0] op,
                                     input logic [2:0] src, input logic [2:0] dst,
                                     input logic [15:0] outv);
    return {strb, op, src, dst, outv};
  endfunction

  task automatic add(input string tag, input logic [15:0] instr, input logic [3:0] flg,
                     input logic rdy, input logic [10:0] strb, input logic [3:0] op,
                     input logic [2:0] src, input logic [2:0] dst, input logic [15:0] outv);
    vec_t v;
    v.tag   = tag;
    v.instr = instr;
    v.flg   = flg;
    v.rdy   = rdy;
    v.expv  = ex(strb, op, src, dst, outv);
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input string tag, input logic [15:0] instr, input logic [3:0] flg);
    add({tag, " FETCH_A"}, instr, flg, 1'b1, S_ROUT | S_MADDR, 4'd0, 3'd0, 3'd0, 16'h0);
    add({tag, " FETCH_D"}, instr, flg, 1'b1, S_MOUT, 4'd0, 3'd0, 3'd0, 16'h0);
    add({tag, " DECODE"},  instr, flg, 1'b1, S_PCINC, 4'd0, 3'd0, 3'd0, 16'h0);
  endtask

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual no finish by 100us, required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in_w = '0; flags_w = '0; mem_ready = 1'b1; mem_ready_b = 1'b0;
`ifdef MICROSEQ_IRQ_EN
    irq_w = 1'b0;
`endif
    add_fetch("ld_imm", 16'h1B05, 4'h0);
    add("ld_imm EX1", 16'h1B05, 4'h0, 1'b1, S_OUTEN | S_RIN, 4'd0, 3'd0, 3'd3, 16'h0005);
    add_fetch("add", 16'h3120, 4'h0);
    add("add EX1", 16'h3120, 4'h0, 1'b1, S_ROUT, 4'd3, 3'd2, 3'd1, 16'h0);
    add("add EX2", 16'h3120, 4'h0, 1'b1, S_AOUT | S_RIN, 4'd3, 3'd0, 3'd1, 16'h0);
    add_fetch("cmp", 16'hE120, 4'h0);
    add("cmp EX1", 16'hE120, 4'h0, 1'b1, S_ROUT, 4'd14, 3'd2, 3'd1, 16'h0);
    add("cmp EX2", 16'hE120, 4'h0, 1'b1, S_NONE, 4'd14, 3'd0, 3'd1, 16'h0);
    add_fetch("br_z_taken", 16'hF105, 4'b0001);
    add("br_z_taken EX1", 16'hF105, 4'b0001, 1'b1, S_OUTEN | S_RIN, 4'd0, 3'd0, 3'd0, 16'h0005);
    add_fetch("br_z_not", 16'hF105, 4'b0000);
    add("br_z_not EX1", 16'hF105, 4'b0000, 1'b1, S_NONE, 4'd0, 3'd0, 3'd0, 16'h0);
    add_fetch("br_sext", 16'hF0FF, 4'b0000);
    add("br_sext EX1", 16'hF0FF, 4'b0000, 1'b1, S_OUTEN | S_RIN, 4'd0, 3'd0, 3'd0, 16'hFFFF);
    add_fetch("ld_mem", 16'h1120, 4'h0);
    add("ld_mem EX1", 16'h1120, 4'h0, 1'b1, S_ROUT | S_MADDR, 4'd0, 3'd2, 3'd0, 16'h0);
    for (int i = 0; i < 3; i++)
      add("ld_mem EX2 wait", 16'h1120, 4'h0, 1'b0, S_MOUT | S_RIN, 4'd0, 3'd0, 3'd1, 16'h0);
    add("ld_mem EX2 ready", 16'h1120, 4'h0, 1'b1, S_MOUT | S_RIN, 4'd0, 3'd0, 3'd1, 16'h0);
    add_fetch("st", 16'h2340, 4'h0);
    add("st EX1", 16'h2340, 4'h0, 1'b1, S_ROUT | S_MADDR, 4'd0, 3'd3, 3'd0, 16'h0);
    add("st EX2", 16'h2340, 4'h0, 1'b1, S_ROUT | S_MIN, 4'd0, 3'd4, 3'd0, 16'h0);
    add_fetch("shr_ar", 16'hBAD7, 4'h0);
    add("shr_ar EX1", 16'hBAD7, 4'h0, 1'b1, S_OUTEN | S_AR, 4'd11, 3'd5, 3'd2, 16'h0007);
    add("shr_ar EX2", 16'hBAD7, 4'h0, 1'b1, S_AOUT | S_RIN | S_AR, 4'd11, 3'd0, 3'd2, 16'h0);
    add_fetch("jsr", 16'hD760, 4'h0);
    add("jsr EX1", 16'hD760, 4'h0, 1'b1, S_ROUT | S_RIN, 4'd0, 3'd0, 3'd7, 16'h0);
    add("jsr EX2", 16'hD760, 4'h0, 1'b1, S_ROUT | S_RIN, 4'd0, 3'd6, 3'd0, 16'h0);
    add_fetch("jmp_imm", 16'hC803, 4'h0);
    add("jmp_imm EX1", 16'hC803, 4'h0, 1'b1, S_OUTEN | S_RIN, 4'd0, 3'd0, 3'd0, 16'h0003);
    add_fetch("halt", 16'h0001, 4'h0);
    add("halt EX1", 16'h0001, 4'h0, 1'b1, S_NONE, 4'd0, 3'd0, 3'd0, 16'h0);
    for (int i = 0; i < 4; i++)
      add("halt held", 16'h0001, 4'h0, i[0], S_HALT, 4'd0, 3'd0, 3'd0, 16'h0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_a", act_a, '0);
    check("reset_b", act_b, '0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      in_w      = vecs[i].instr;
      flags_w   = vecs[i].flg;
      mem_ready = vecs[i].rdy;
      @(negedge clk);
      check(vecs[i].tag, act_a, vecs[i].expv);
      $display("%-18s in=%h rdy=%0b act=%h exp=%h", vecs[i].tag, vecs[i].instr, vecs[i].rdy,
               act_a, vecs[i].expv);
      tick();
    end

    // Asynchronous reset out of HALT, then again in the middle of a waiting LD EX2.
    rst = 1'b0;
    #1;
    check("reset_from_halt", act_a, '0);
    tick();
    rst = 1'b1; mem_ready = 1'b1; in_w = 16'h1120;
    repeat (4) tick();
    mem_ready = 1'b0;
    @(negedge clk);
    check("ld_ex2_before_reset", act_a, ex(S_MOUT | S_RIN, 4'd0, 3'd0, 3'd1, 16'h0));
    #2 rst = 1'b0;
    #1;
    check("reset_async_mid_ex2", act_a, '0);
    $display("reset mid EX2: act=%h", act_a);
    tick();
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("fetch_after_reset", act_a, ex(S_ROUT | S_MADDR, 4'd0, 3'd0, 3'd0, 16'h0));
    tick();

    // WAIT_MAX=2 instance: two waiting cycles, then FAULT.
    rst = 1'b0; tick(); rst = 1'b1; mem_ready_b = 1'b0;
    @(negedge clk);
    check("b_fetch_a", act_b, ex(S_ROUT | S_MADDR, 4'd0, 3'd0, 3'd0, 16'h0));
    tick();
    @(negedge clk);
    check("b_wait0", act_b, ex(S_MOUT, 4'd0, 3'd0, 3'd0, 16'h0));
    tick();
    @(negedge clk);
    check("b_wait1", act_b, ex(S_MOUT, 4'd0, 3'd0, 3'd0, 16'h0));
    tick();
    @(negedge clk);
    check("b_fault", act_b, ex(S_FAULT, 4'd0, 3'd0, 3'd0, 16'h0));
    $display("timeout: act_b=%h", act_b);
    repeat (3) tick();
    mem_ready_b = 1'b1;
    @(negedge clk);
    check("b_fault_held", act_b, ex(S_FAULT, 4'd0, 3'd0, 3'd0, 16'h0));
    tick();

    // mem_ready on the limit edge wins over the timeout.
    rst = 1'b0; tick(); rst = 1'b1; mem_ready_b = 1'b0;
    tick();
    tick();
    mem_ready_b = 1'b1;
    @(negedge clk);
    check("b_limit_edge", act_b, ex(S_MOUT, 4'd0, 3'd0, 3'd0, 16'h0));
    tick();
    @(negedge clk);
    check("b_ready_wins", act_b, ex(S_PCINC, 4'd0, 3'd0, 3'd0, 16'h0));
    $display("ready on limit edge: act_b=%h", act_b);
    tick();

`ifdef MICROSEQ_IRQ_EN
    rst = 1'b0; tick(); rst = 1'b1; mem_ready = 1'b1; in_w = 16'h0002;
    repeat (4) tick();
    irq_w = 1'b1;
    @(negedge clk);
    check("irq_fetch_a", act_a, ex(S_ROUT | S_MADDR, 4'd0, 3'd0, 3'd0, 16'h0));
    tick();
    @(negedge clk);
    check("irq1", act_a, ex(S_ROUT | S_RIN, 4'd0, 3'd0, 3'd7, 16'h0));
    check("irq1_ack", 37'(irq_ack_a), 37'd0);
    tick();
    @(negedge clk);
    check("irq2", act_a, ex(S_OUTEN | S_RIN, 4'd0, 3'd0, 3'd0, 16'h0010));
    check("irq2_ack", 37'(irq_ack_a), 37'd1);
    tick();
    @(negedge clk);
    check("irq_back_fetch_a", act_a, ex(S_ROUT | S_MADDR, 4'd0, 3'd0, 3'd0, 16'h0));
    tick();
    @(negedge clk);
    check("irq_ignored", act_a, ex(S_MOUT, 4'd0, 3'd0, 3'd0, 16'h0));
    check("irq_ignored_ack", 37'(irq_ack_a), 37'd0);
    $display("irq sequence: act_a=%h", act_a);
    irq_w = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
